disp_mux_capture: RTL and testbench
===================================

Name: disp_mux_capture

Overview:
- Receive-side counterpart of the time-multiplexed 4-digit seven-segment driver.
- Samples the active-low anode and segment buses, decodes each stably displayed digit back to a hex nibble and decimal point, and holds the latest value of all four digits.
- Used for loopback self-check on the board (driver outputs tapped back in) and as a synthesizable monitor in display testbenches.

Parameters:
- SETTLE, 4: consecutive identical synchronized samples required before a digit is captured (min 1).
- TO_W, 18: width of the no-capture timeout counter; timeout fires at 2^TO_W-1 cycles.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- an  in  4  anode enables, active-low; an[i]=0 selects digit i
- sseg  in  8  segments, active-low; sseg[7]=dp, sseg[6:0]={g,f,e,d,c,b,a}
- hex3, hex2, hex1, hex0  out  4 each  decoded digit values
- dp_out  out  4  dp_out[i]=1 when digit i's decimal point was lit
- digit_err  out  4  digit_err[i]=1 when digit i's last pattern was not a hex glyph
- frame_valid  out  1  all four digits captured since the last timeout
- frame_tick  out  1  one-cycle pulse on each completed frame
- blank_timeout  out  1  no capture for 2^TO_W-1 cycles

Behaviour:
- Reset (async, reset_n=0): all outputs 0; synchronizers, settle counter, timeout counter and seen[3:0] cleared. Reset mid-dwell discards the partial dwell.
- Input sync: an and sseg pass through a two-flop synchronizer (12 bits, same stages).
- Settle:
  - The synchronized {an,sseg} value is compared with its value on the previous cycle.
  - Any difference zeroes the settle counter and clears the captured flag.
  - Otherwise the counter increments, saturating at SETTLE.
- Capture condition: counter reaches SETTLE, captured flag clear, and synchronized an has exactly one 0 bit. On that edge the flag is set, so there is at most one capture per dwell.
- No capture: an=4'b1111 (blanking) or more than one 0 bit. Counting still proceeds.
- Latency: pins stable from edge k, so the capture edge is k+1+SETTLE and outputs are valid after edge k+1+SETTLE.
- Capture of digit i (index of the 0 bit):
  - Glyph table, sseg[6:0] -> value: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - Matching glyph: hex_i <= value, digit_err[i] <= 0.
  - No match (including all-off 1111111): hex_i <= 0, digit_err[i] <= 1.
  - dp_out[i] <= ~sseg[7]; seen[i] <= 1.
- Frame:
  - The cycle after a capture makes seen==4'b1111: frame_tick=1 for exactly one cycle, frame_valid <= 1, seen <= 0.
  - Recapturing an already-seen digit does not complete a frame. Captures in any order count.
- Timeout:
  - The counter clears on every capture and otherwise increments, saturating at 2^TO_W-1.
  - At saturation: blank_timeout=1, frame_valid <= 0, seen <= 0.
  - The next capture clears blank_timeout on the same edge. frame_valid re-asserts only on the next full frame.
- Simultaneous events: a capture on the timeout-saturation cycle wins (counter clears, no timeout). The frame completion check uses the post-capture seen.
- hex/dp/err outputs hold their last captured values through timeout; only frame_valid drops.

Test Plan:
- Reset: reset_n low with arbitrary inputs -> all outputs 0. Release, then drive an=1111 for 300k cycles at TO_W=18 -> blank_timeout=1 at cycle 262143, frame_valid=0.
- Normal frame, SETTLE=4: cycle an 1110/1101/1011/0111 at 16 cycles each with glyphs 5,A,0,F and dp lit on digit 2.
  - hex0=5, hex1=A, hex2=0, hex3=F, dp_out=0100, digit_err=0000.
  - frame_tick pulses once per 64-cycle frame; frame_valid=1 from the first frame.
- Latency: step an 1111->1110 with sseg=0100100 at edge k -> hex0 becomes 2 exactly at edge k+5. A 4-cycle dwell never captures.
- Glitches: an=1100 and an=1111 dwells -> no capture, seen unchanged. A sseg glitch mid-dwell restarts the settle count and produces one capture only.
- Invalid glyph: sseg[6:0]=1111111 on digit 1 -> hex1=0, digit_err[1]=1. Next frame with glyph 7 -> hex1=7, digit_err[1]=0.
- Boundary and reset: only digits 0-2 displayed -> no frame_tick ever. Asserting reset_n=0 mid-dwell -> outputs 0 immediately, not on a clock edge. After release, a full frame is needed before frame_valid=1.

Source files
------------

// File: rtl/disp_mux_capture.sv
// disp_mux_capture: recovers the four digits shown by a time-multiplexed,
// active-low seven-segment driver by watching its anode and segment buses.
module disp_mux_capture #(
  parameter int SETTLE = 4,
  parameter int TO_W   = 18
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] dp_out,
  output logic [3:0] digit_err,
  output logic       frame_valid,
  output logic       frame_tick,
  output logic       blank_timeout
);

  localparam int              CW       = $clog2(SETTLE + 1);
  localparam logic [CW-1:0]   SETTLE_C = CW'(SETTLE);
  localparam logic [TO_W-1:0] TO_MAX   = '1;

  // {err, value}; anything outside the sixteen hex glyphs is an error
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1000000: r = 5'h00;
      7'b1111001: r = 5'h01;
      7'b0100100: r = 5'h02;
      7'b0110000: r = 5'h03;
      7'b0011001: r = 5'h04;
      7'b0010010: r = 5'h05;
      7'b0000010: r = 5'h06;
      7'b1111000: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0010000: r = 5'h09;
      7'b0001000: r = 5'h0a;
      7'b0000011: r = 5'h0b;
      7'b1000110: r = 5'h0c;
      7'b0100001: r = 5'h0d;
      7'b0000110: r = 5'h0e;
      7'b0001110: r = 5'h0f;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  logic [11:0]      sync1_q, sync1_d;
  logic [11:0]      sync2_q, sync2_d;
  logic [CW-1:0]    settle_q, settle_d;
  logic             captured_q, captured_d;
  logic [3:0]       seen_q, seen_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [3:0][3:0]  hex_q, hex_d;
  logic [3:0]       dp_q, dp_d;
  logic [3:0]       err_q, err_d;
  logic             fvalid_q, fvalid_d;
  logic             ftick_q, ftick_d;
  logic             blank_q, blank_d;

  logic             stable;
  logic             sel_valid;
  logic [1:0]       sel;
  logic             capture;
  logic             timeout;
  logic [4:0]       glyph;
  logic [3:0]       seen_next;

  always_comb begin
    sync1_d    = {an, sseg};
    sync2_d    = sync1_q;

    // sync1 is one cycle ahead of sync2, so equality means sync2 will hold
    stable     = (sync1_q == sync2_q);
    if (!stable) begin
      settle_d = '0;
    end else if (settle_q == SETTLE_C) begin
      settle_d = settle_q;
    end else begin
      settle_d = settle_q + 1'b1;
    end

    sel        = 2'd0;
    sel_valid  = 1'b1;
    case (sync2_q[11:8])
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: sel_valid = 1'b0;
    endcase

    capture    = (settle_d == SETTLE_C) && !captured_q && sel_valid;
    captured_d = stable && (captured_q || capture);

    glyph      = decode_glyph(sync2_q[6:0]);
    hex_d      = hex_q;
    dp_d       = dp_q;
    err_d      = err_q;
    seen_next  = seen_q;
    if (capture) begin
      hex_d[sel] = glyph[3:0];
      err_d[sel] = glyph[4];
      dp_d[sel]  = ~sync2_q[7];
      seen_next  = seen_q | (4'b0001 << sel);
    end

    if (capture) begin
      to_d = TO_MAX;
    end else if (to_q != '0) begin
      to_d = to_q - 1'b1;
    end else begin
      to_d = '0;
    end
    timeout    = (to_d == '0);
    blank_d    = timeout;

    seen_d     = seen_next;
    fvalid_d   = fvalid_q;
    ftick_d    = 1'b0;
    if (seen_next == 4'b1111) begin
      ftick_d  = 1'b1;
      fvalid_d = 1'b1;
      seen_d   = 4'b0000;
    end
    if (timeout) begin
      fvalid_d = 1'b0;
      seen_d   = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      settle_q   <= '0;
      captured_q <= 1'b0;
      seen_q     <= '0;
      to_q       <= TO_MAX;
      hex_q      <= '0;
      dp_q       <= '0;
      err_q      <= '0;
      fvalid_q   <= 1'b0;
      ftick_q    <= 1'b0;
      blank_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      settle_q   <= settle_d;
      captured_q <= captured_d;
      seen_q     <= seen_d;
      to_q       <= to_d;
      hex_q      <= hex_d;
      dp_q       <= dp_d;
      err_q      <= err_d;
      fvalid_q   <= fvalid_d;
      ftick_q    <= ftick_d;
      blank_q    <= blank_d;
    end
  end

  assign hex0          = hex_q[0];
  assign hex1          = hex_q[1];
  assign hex2          = hex_q[2];
  assign hex3          = hex_q[3];
  assign dp_out        = dp_q;
  assign digit_err     = err_q;
  assign frame_valid   = fvalid_q;
  assign frame_tick    = ftick_q;
  assign blank_timeout = blank_q;

endmodule

// File: tb/tb_disp_mux_capture.sv
// Bench for disp_mux_capture: directed scenarios then random dwells, all checked
// against a dwell-level model of the capture rules.
module tb_disp_mux_capture;

  localparam int SETTLE = 4;
  localparam int TO_W   = 10;
  localparam int TO_MAX = (1 << TO_W) - 1;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic       clk;
  logic       reset_n;
  logic [3:0] an_i;
  logic [7:0] sseg_i;
  logic [3:0] hex3, hex2, hex1, hex0;
  logic [3:0] dp_out, digit_err;
  logic       frame_valid, frame_tick, blank_timeout;

  disp_mux_capture #(.SETTLE(SETTLE), .TO_W(TO_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .an           (an_i),
    .sseg         (sseg_i),
    .hex3         (hex3),
    .hex2         (hex2),
    .hex1         (hex1),
    .hex0         (hex0),
    .dp_out       (dp_out),
    .digit_err    (digit_err),
    .frame_valid  (frame_valid),
    .frame_tick   (frame_tick),
    .blank_timeout(blank_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // model state
  logic [3:0] hex_m [4];
  logic [3:0] dp_m, err_m, seen_m;
  logic       fv_m;
  int         n_m;
  logic [11:0] last_pins;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int digit_of(input logic [3:0] a);
    for (int i = 0; i < 4; i++)
      if (a == ~(4'b0001 << i)) return i;
    return -1;
  endfunction

  function automatic logic [4:0] glyph_lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (GLYPH[i] == s) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  function automatic logic [24:0] obs_vec();
    return {hex3, hex2, hex1, hex0, dp_out, digit_err, blank_timeout};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) hex_m[i] = 4'h0;
    dp_m = 4'h0; err_m = 4'h0; seen_m = 4'h0; fv_m = 1'b0; n_m = 0;
    last_pins = 12'h000;
  endtask

  // A dwell of len cycles captures when the pins stay put for more than SETTLE
  // cycles; the capture lands on the (SETTLE+2)-th edge of the dwell. A dwell of
  // exactly SETTLE+1 captures on the edge that starts the next dwell, so the
  // stimulus never uses that length.
  task automatic model_dwell(input logic [3:0] a, input logic [7:0] s, input int len,
                             output int exp_ticks);
    int d;
    logic [4:0] g;
    d = digit_of(a);
    exp_ticks = 0;
    if (d >= 0 && len > SETTLE) begin
      if (n_m + SETTLE + 1 >= TO_MAX) begin seen_m = 4'h0; fv_m = 1'b0; end
      g = glyph_lookup(s[6:0]);
      hex_m[d]  = g[3:0];
      err_m[d]  = g[4];
      dp_m[d]   = ~s[7];
      seen_m[d] = 1'b1;
      if (seen_m == 4'hf) begin exp_ticks = 1; fv_m = 1'b1; seen_m = 4'h0; end
      n_m = len - (SETTLE + 2);
    end else begin
      n_m = n_m + len;
      if (n_m >= TO_MAX) begin seen_m = 4'h0; fv_m = 1'b0; end
    end
  endtask

  // called #1 after a rising edge; returns the dwell edge index of the first
  // visible output change, or -1
  task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int len,
                       output int first_chg);
    logic [24:0] snap;
    int ticks, exp_ticks;
    snap = obs_vec();
    an_i = a;
    sseg_i = s;
    ticks = 0;
    first_chg = -1;
    for (int i = 1; i <= len; i++) begin
      @(posedge clk);
      #1;
      if (frame_tick) ticks++;
      if (first_chg < 0 && obs_vec() != snap) first_chg = i;
    end
    model_dwell(a, s, len, exp_ticks);
    check("hex",   32'({hex3, hex2, hex1, hex0}), 32'({hex_m[3], hex_m[2], hex_m[1], hex_m[0]}));
    check("dp",    32'(dp_out), 32'(dp_m));
    check("err",   32'(digit_err), 32'(err_m));
    check("fvalid",32'(frame_valid), 32'(fv_m));
    check("blank", 32'(blank_timeout), 32'(n_m >= TO_MAX));
    check("ticks", 32'(ticks), 32'(exp_ticks));
    last_pins = {a, s};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hex"},   32'({hex3, hex2, hex1, hex0}), 32'h0);
    check({tag, "_dp"},    32'(dp_out), 32'h0);
    check({tag, "_err"},   32'(digit_err), 32'h0);
    check({tag, "_fv"},    32'(frame_valid), 32'h0);
    check({tag, "_tick"},  32'(frame_tick), 32'h0);
    check({tag, "_blank"}, 32'(blank_timeout), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc;
    logic [3:0] a;
    logic [7:0] s;
    int len;
    logic [7:0] s_to;

    // reset with arbitrary inputs
    reset_n = 1'b0;
    an_i    = 4'($urandom);
    sseg_i  = 8'($urandom);
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check_all_zero("reset");

    // release and blank: timeout exactly TO_MAX edges after release
    s_to = 8'($urandom);
    reset_n = 1'b1;
    an_i = 4'hf;
    sseg_i = s_to;
    repeat (TO_MAX - 1) @(posedge clk);
    #1;
    check("blank_early", 32'(blank_timeout), 32'h0);
    @(posedge clk);
    #1;
    check("blank_at_max", 32'(blank_timeout), 32'h1);
    check("fv_at_max", 32'(frame_valid), 32'h0);
    repeat (10) @(posedge clk);
    #1;
    n_m = TO_MAX + 10;
    last_pins = {4'hf, s_to};

    // latency: capture exactly SETTLE+1 edges after the first sampling edge
    dwell(4'b1110, {1'b1, GLYPH[2]}, 8, fc);
    check("latency", 32'(fc), 32'(SETTLE + 2));
    // a dwell of SETTLE cycles never captures, even afterwards
    dwell(4'b1101, {1'b1, GLYPH[3]}, SETTLE, fc);
    check("short_dwell", 32'(fc), 32'hffffffff);
    dwell(4'b1111, {1'b1, GLYPH[3]}, 8, fc);
    check("short_dwell_after", 32'(fc), 32'hffffffff);

    // normal frames: 5, A, 0 (dp lit), F
    for (int f = 0; f < 2; f++) begin
      dwell(4'b1110, {1'b1, GLYPH[5]},  16, fc);
      dwell(4'b1101, {1'b1, GLYPH[10]}, 16, fc);
      dwell(4'b1011, {1'b0, GLYPH[0]},  16, fc);
      dwell(4'b0111, {1'b1, GLYPH[15]}, 16, fc);
    end

    // multi-anode and blanking dwells, then a segment glitch mid-dwell
    dwell(4'b1110, {1'b1, GLYPH[1]}, 16, fc);
    dwell(4'b1101, {1'b1, GLYPH[2]}, 16, fc);
    dwell(4'b1100, {1'b1, GLYPH[8]}, 12, fc);
    check("multi_anode", 32'(fc), 32'hffffffff);
    dwell(4'b1111, {1'b1, GLYPH[8]}, 12, fc);
    dwell(4'b1011, {1'b1, GLYPH[3]}, 3, fc);
    dwell(4'b1011, {1'b1, GLYPH[8]}, 1, fc);
    dwell(4'b1011, {1'b1, GLYPH[3]}, 12, fc);
    check("glitch_restart", 32'(fc), 32'(SETTLE + 2));
    dwell(4'b0111, {1'b1, GLYPH[4]}, 16, fc);

    // invalid glyph on digit 1, then a valid 7
    dwell(4'b1110, {1'b1, GLYPH[0]}, 10, fc);
    dwell(4'b1101, 8'hff,            10, fc);
    dwell(4'b1011, {1'b1, GLYPH[2]}, 10, fc);
    dwell(4'b0111, {1'b1, GLYPH[3]}, 10, fc);
    dwell(4'b1110, {1'b1, GLYPH[0]}, 10, fc);
    dwell(4'b1101, {1'b1, GLYPH[7]}, 10, fc);
    dwell(4'b1011, {1'b1, GLYPH[2]}, 10, fc);
    dwell(4'b0111, {1'b1, GLYPH[3]}, 10, fc);

    // only digits 0-2: never a frame
    for (int r = 0; r < 3; r++) begin
      dwell(4'b1110, {1'b1, GLYPH[r + 9]},  10, fc);
      dwell(4'b1101, {1'b0, GLYPH[r + 11]}, 10, fc);
      dwell(4'b1011, {1'b1, GLYPH[r + 1]},  10, fc);
    end

    // asynchronous reset in the middle of a dwell
    an_i = 4'b0111;
    sseg_i = {1'b0, GLYPH[9]};
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    dwell(4'b1110, {1'b1, GLYPH[6]}, 10, fc);
    dwell(4'b1101, {1'b1, GLYPH[7]}, 10, fc);
    dwell(4'b1011, {1'b1, GLYPH[8]}, 10, fc);
    check("fv_partial", 32'(frame_valid), 32'h0);
    dwell(4'b0111, {1'b1, GLYPH[9]}, 10, fc);
    check("fv_full", 32'(frame_valid), 32'h1);

    // random dwells
    for (int n = 0; n < 150; n++) begin
      do begin
        case ($urandom_range(0, 9))
          6:       a = 4'hf;
          7:       a = 4'($urandom);
          default: a = ~(4'b0001 << $urandom_range(0, 3));
        endcase
        if ($urandom_range(0, 3) != 0) s = {1'($urandom), GLYPH[$urandom_range(0, 15)]};
        else                           s = 8'($urandom);
      end while ({a, s} == last_pins);
      if ($urandom_range(0, 2) == 0) len = $urandom_range(1, SETTLE);
      else                           len = $urandom_range(SETTLE + 2, 20);
      dwell(a, s, len, fc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
